// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch redirect flush and
// memory-wait stall with a fatal timeout, plus a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic        memrd_ex,
  input  logic        RegWrite_ex,
  input  logic        Predicate_ex,
  input  logic [4:0]  RW_ex,
  input  logic        redirect_ex,
  input  logic        mem_req_mem,
  input  logic        mem_ready,
  input  logic        stat_clr,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_bubble,
  output logic        mem_timeout,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StErr     = 2'd2
  } state_e;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  wait_inc;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        mem_stall;
  logic        load_use;
  logic        rs_match;
  logic        stall_evt;

  assign mem_stall = mem_req_mem & ~mem_ready;
  assign rs_match  = (use_rs1 & (rs1_id == RW_ex)) | (use_rs2 & (rs2_id == RW_ex));
  assign load_use  = memrd_ex & RegWrite_ex & Predicate_ex & (RW_ex != 5'd0) & rs_match;
  assign wait_inc  = wait_cnt_q + 8'd1;

  // A redirect squashes the wrong-path load-use stall, so it never counts alone.
  assign stall_evt = (state_q != StErr) & (mem_stall | (load_use & ~redirect_ex));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd1;
        end
      end
      StMemWait: begin
        if (mem_stall) begin
          wait_cnt_d = wait_inc;
          if (wait_inc == TimeoutVal) state_d = StErr;
        end else begin
          state_d    = StRun;
          wait_cnt_d = 8'd0;
        end
      end
      StErr: ;
      default: begin
        state_d    = StRun;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr) begin
      stall_cnt_d = 16'd0;
    end else if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Default is the frozen, bubbling pipeline used for reset, ERR and memory stall.
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b1;
    if (reset && (state_q != StErr) && !mem_stall) begin
      memwb_bubble = 1'b0;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      if (redirect_ex) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        idex_flush = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
      end
    end
  end

  assign state       = state_q;
  assign mem_timeout = (state_q == StErr);
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with TIMEOUT=4
// shares the inputs so the fatal timeout path can be reached quickly.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_id, rs2_id, RW_ex;
  logic        use_rs1, use_rs2, memrd_ex, RegWrite_ex, Predicate_ex;
  logic        redirect_ex, mem_req_mem, mem_ready, stat_clr;

  logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble;
  logic        mem_timeout;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  logic        pc_en_t, ifid_en_t, idex_en_t, exmem_en_t, ifid_flush_t, idex_flush_t;
  logic        memwb_bubble_t, mem_timeout_t;
  logic [1:0]  state_t;
  logic [15:0] stall_cnt_t;

  logic [6:0]  ctl, ctl_t;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
  localparam logic [6:0] CtlRun   = 7'b1111000;
  localparam logic [6:0] CtlStall = 7'b0000001;
  localparam logic [6:0] CtlRedir = 7'b1111110;
  localparam logic [6:0] CtlLu    = 7'b0011010;

  always #5 clk = ~clk;

  assign ctl   = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};
  assign ctl_t = {pc_en_t, ifid_en_t, idex_en_t, exmem_en_t, ifid_flush_t, idex_flush_t,
                  memwb_bubble_t};

  pipe_hazard_ctrl u_dut (
    .clk          (clk),
    .reset        (reset),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .use_rs1      (use_rs1),
    .use_rs2      (use_rs2),
    .memrd_ex     (memrd_ex),
    .RegWrite_ex  (RegWrite_ex),
    .Predicate_ex (Predicate_ex),
    .RW_ex        (RW_ex),
    .redirect_ex  (redirect_ex),
    .mem_req_mem  (mem_req_mem),
    .mem_ready    (mem_ready),
    .stat_clr     (stat_clr),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .memwb_bubble (memwb_bubble),
    .mem_timeout  (mem_timeout),
    .state        (state),
    .stall_cnt    (stall_cnt)
  );

  pipe_hazard_ctrl #(.TIMEOUT(4)) u_dut_t4 (
    .clk          (clk),
    .reset        (reset),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .use_rs1      (use_rs1),
    .use_rs2      (use_rs2),
    .memrd_ex     (memrd_ex),
    .RegWrite_ex  (RegWrite_ex),
    .Predicate_ex (Predicate_ex),
    .RW_ex        (RW_ex),
    .redirect_ex  (redirect_ex),
    .mem_req_mem  (mem_req_mem),
    .mem_ready    (mem_ready),
    .stat_clr     (stat_clr),
    .pc_en        (pc_en_t),
    .ifid_en      (ifid_en_t),
    .idex_en      (idex_en_t),
    .exmem_en     (exmem_en_t),
    .ifid_flush   (ifid_flush_t),
    .idex_flush   (idex_flush_t),
    .memwb_bubble (memwb_bubble_t),
    .mem_timeout  (mem_timeout_t),
    .state        (state_t),
    .stall_cnt    (stall_cnt_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1_id = 5'd0; rs2_id = 5'd0; RW_ex = 5'd0;
    use_rs1 = 1'b0; use_rs2 = 1'b0;
    memrd_ex = 1'b0; RegWrite_ex = 1'b0; Predicate_ex = 1'b0;
    redirect_ex = 1'b0; mem_req_mem = 1'b0; mem_ready = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rw, input logic pred);
    memrd_ex = 1'b1; RegWrite_ex = 1'b1; Predicate_ex = pred; RW_ex = rw;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #1;
    check("rst_ctl", 32'(ctl), 32'(CtlStall));
    check("rst_state", 32'(state), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    check("rst_tmo", 32'(mem_timeout), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("idle_ctl", 32'(ctl), 32'(CtlRun));

    // Load-use on rs1: one stall cycle, counted once.
    set_load(5'd5, 1'b1); rs1_id = 5'd5; use_rs1 = 1'b1;
    #1;
    check("lu_ctl", 32'(ctl), 32'(CtlLu));
    tick();
    idle_inputs();
    #1;
    check("lu_cnt", 32'(stall_cnt), 32'd1);
    check("lu_after_ctl", 32'(ctl), 32'(CtlRun));

    // Predicated-off load, x0 destination, unused rs2: no stall.
    set_load(5'd5, 1'b0); rs1_id = 5'd5; use_rs1 = 1'b1;
    #1;
    check("pred_off_ctl", 32'(ctl), 32'(CtlRun));
    set_load(5'd0, 1'b1); rs1_id = 5'd0;
    #1;
    check("rw0_ctl", 32'(ctl), 32'(CtlRun));
    set_load(5'd7, 1'b1); rs1_id = 5'd3; rs2_id = 5'd7; use_rs2 = 1'b0;
    #1;
    check("rs2_unused_ctl", 32'(ctl), 32'(CtlRun));
    use_rs1 = 1'b0; use_rs2 = 1'b1;
    #1;
    check("rs2_lu_ctl", 32'(ctl), 32'(CtlLu));
    tick();
    check("rs2_lu_cnt", 32'(stall_cnt), 32'd2);

    // Redirect overrides a load-use match and is not counted.
    redirect_ex = 1'b1;
    #1;
    check("redir_ctl", 32'(ctl), 32'(CtlRedir));
    tick();
    idle_inputs();
    #1;
    check("redir_cnt", 32'(stall_cnt), 32'd2);

    // Ready in the same cycle as the request is no stall.
    mem_req_mem = 1'b1; mem_ready = 1'b1;
    #1;
    check("req_ready_ctl", 32'(ctl), 32'(CtlRun));
    tick();
    check("req_ready_state", 32'(state), 32'd0);

    // Three-cycle memory wait, redirect ignored during the stall.
    mem_ready = 1'b0; redirect_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mw_ctl%0d", i), 32'(ctl), 32'(CtlStall));
      tick();
      check($sformatf("mw_state%0d", i), 32'(state), 32'd1);
    end
    redirect_ex = 1'b0; mem_ready = 1'b1;
    #1;
    check("mw_done_ctl", 32'(ctl), 32'(CtlRun));
    tick();
    idle_inputs();
    #1;
    check("mw_done_state", 32'(state), 32'd0);
    check("mw_cnt", 32'(stall_cnt), 32'd5);

    // Timeout on the TIMEOUT=4 instance; one extra stall cycle inside ERR.
    mem_req_mem = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t4_state3", 32'(state_t), 32'd1);
    check("t4_tmo3", 32'(mem_timeout_t), 32'd0);
    tick();
    check("t4_state4", 32'(state_t), 32'd2);
    check("t4_tmo4", 32'(mem_timeout_t), 32'd1);
    check("t4_main_state", 32'(state), 32'd1);
    tick();
    idle_inputs();
    #1;
    check("t4_err_ctl", 32'(ctl_t), 32'(CtlStall));
    check("main_back_ctl", 32'(ctl), 32'(CtlRun));
    tick();
    check("t4_err_held", 32'(state_t), 32'd2);
    check("t4_cnt", 32'(stall_cnt_t), 32'd9);
    check("main_cnt", 32'(stall_cnt), 32'd10);
    check("main_state", 32'(state), 32'd0);

    // Asynchronous reset out of ERR.
    #2;
    reset = 1'b0;
    #1;
    check("t4_rst_state", 32'(state_t), 32'd0);
    check("t4_rst_tmo", 32'(mem_timeout_t), 32'd0);
    check("t4_rst_cnt", 32'(stall_cnt_t), 32'd0);
    check("t4_rst_ctl", 32'(ctl_t), 32'(CtlStall));
    tick();
    reset = 1'b1;
    #1;
    check("t4_resume_ctl", 32'(ctl_t), 32'(CtlRun));

    // Saturation via back-to-back load-use stalls, then clear beats increment.
    set_load(5'd9, 1'b1); rs1_id = 5'd9; use_rs1 = 1'b1;
    repeat (65535) tick();
    check("sat_fill", 32'(stall_cnt), 32'hFFFF);
    tick();
    check("sat_hold", 32'(stall_cnt), 32'hFFFF);
    stat_clr = 1'b1;
    tick();
    check("sat_clr", 32'(stall_cnt), 32'd0);
    idle_inputs();
    tick();
    check("sat_clr_idle", 32'(stall_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
